// File: rtl/instruct_mem_loader.sv
// ---------------------------------------------------------------------------
// instruct_mem_loader
//
// Purpose:
//   Streams a byte-serial program image into a 32-bit-wide instruction memory
//   write port. Bytes are packed little-endian into words, and each completed
//   word is written with a single-cycle strobe. While a load is in progress,
//   busy holds the processor in reset. A load ends in DONE when the image
//   ends with byte_last. It ends in ERROR when the image would run past
//   MEM_SIZE bytes.
//
// Ports:
//   clk         in   single clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   begin a load session at byte address 0
//   byte_valid  in   byte_data is valid
//   byte_data   in   [7:0] image byte
//   byte_last   in   byte_data is the final image byte
//   byte_ready  out  loader accepts a byte this cycle
//   wr_en       out  one-cycle instruction memory write strobe
//   wr_addr     out  [63:0] byte address of the current word
//   wr_data     out  [31:0] assembled instruction word
//   busy        out  load in progress
//   done        out  image loaded successfully
//   error       out  image overflowed MEM_SIZE
//   word_count  out  words written this session
// ---------------------------------------------------------------------------
module instruct_mem_loader #(
    parameter int MEM_SIZE = 1024
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          byte_valid,
    input  logic [7:0]                    byte_data,
    input  logic                          byte_last,
    output logic                          byte_ready,
    output logic                          wr_en,
    output logic [63:0]                   wr_addr,
    output logic [31:0]                   wr_data,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [$clog2(MEM_SIZE/4):0]   word_count
);

    localparam int WC_W = $clog2(MEM_SIZE/4) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_DONE    = 3'd3,
        S_ERROR   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [63:0]       r_addr;
    logic [31:0]       r_data;
    logic [1:0]        r_lane;
    logic [WC_W-1:0]   r_count;
    logic              r_last_seen;

    logic              w_accept;
    logic [63:0]       w_addr_next;

    assign w_accept    = byte_valid && (r_state == S_COLLECT);
    assign w_addr_next = r_addr + 64'd4;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        w_state_next = r_state;
        byte_ready   = 1'b0;
        busy         = 1'b0;
        wr_en        = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                done  = (r_state == S_DONE);
                error = (r_state == S_ERROR);
                if (start) begin
                    w_state_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (w_accept && ((r_lane == 2'd3) || byte_last)) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                wr_en = 1'b1;
                busy  = 1'b1;
                // A final word always completes as DONE, even when it
                // fills the last location in memory.
                if (r_last_seen) begin
                    w_state_next = S_DONE;
                end else if (w_addr_next == 64'(MEM_SIZE)) begin
                    w_state_next = S_ERROR;
                end else begin
                    w_state_next = S_COLLECT;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Word assembly, address and word counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= 64'd0;
            r_data      <= 32'd0;
            r_lane      <= 2'd0;
            r_count     <= '0;
            r_last_seen <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_addr      <= 64'd0;
                        r_data      <= 32'd0;
                        r_lane      <= 2'd0;
                        r_count     <= '0;
                        r_last_seen <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    // wr_data was cleared after the previous write, so
                    // lanes above a short final word remain zero.
                    if (w_accept) begin
                        r_data[{r_lane, 3'b000} +: 8] <= byte_data;
                        r_lane                        <= r_lane + 2'd1;
                        if (byte_last) begin
                            r_last_seen <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_addr  <= w_addr_next;
                    r_count <= r_count + WC_W'(1);
                    r_lane  <= 2'd0;
                    r_data  <= 32'd0;
                end
                default: begin
                    r_lane <= 2'd0;
                end
            endcase
        end
    end

    assign wr_addr    = r_addr;
    assign wr_data    = r_data;
    assign word_count = r_count;

endmodule
